// File: rtl/dcache_flush_arbiter.sv
// Round-robin arbiter that coalesces fence-style flush requests into a single dcache flush.
// Optional watchdog: define FLUSH_ARB_TIMEOUT_EN to compile it in.
module dcache_flush_arbiter #(
  parameter int NrReq         = 3,
  parameter int TimeoutCycles = 1024,
  localparam int GW           = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NrReq-1:0] req_i,
  output logic [NrReq-1:0] ack_o,
  output logic             flush_dcache_o,
  input  logic             flush_dcache_ack_i,
  input  logic             cache_busy_i,
  output logic             busy_o,
  output logic [GW-1:0]    grant_id_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_e;

  state_e           r_state;
  logic [GW-1:0]    r_rr_ptr;
  logic [NrReq-1:0] r_snap;
  logic [GW-1:0]    w_pick;
  logic [GW-1:0]    w_ptr_next;
  logic             w_expire;
  int               w_idx;

  if (NrReq < 1 || NrReq > 8 || TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_param_err
    $error("dcache_flush_arbiter: parameter out of range");
  end

  // Scan downward so the set bit closest to r_rr_ptr (wrapping upward) is the last to win.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = 0;
    for (int k = NrReq - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NrReq) w_idx = w_idx - NrReq;
      if (req_i[GW'(w_idx)]) w_pick = GW'(w_idx);
    end
  end

  assign w_ptr_next = (grant_id_o == GW'(NrReq - 1)) ? '0 : grant_id_o + GW'(1);

`ifdef FLUSH_ARB_TIMEOUT_EN
  logic [15:0] r_wd;
  assign w_expire = (r_wd == 16'(TimeoutCycles - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_snap         <= '0;
      flush_dcache_o <= 1'b0;
      ack_o          <= '0;
      busy_o         <= 1'b0;
      grant_id_o     <= '0;
      timeout_o      <= 1'b0;
`ifdef FLUSH_ARB_TIMEOUT_EN
      r_wd           <= '0;
`endif
    end else begin
      ack_o     <= '0;
      timeout_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|req_i && !cache_busy_i) begin
            r_state        <= FLUSH;
            r_snap         <= req_i;
            grant_id_o     <= w_pick;
            flush_dcache_o <= 1'b1;
            busy_o         <= 1'b1;
`ifdef FLUSH_ARB_TIMEOUT_EN
            r_wd           <= '0;
`endif
          end
        end
        FLUSH: begin
          // A dcache ack in the expiry cycle wins, so no timeout is flagged then.
          if (flush_dcache_ack_i || w_expire) begin
            r_state        <= DONE;
            flush_dcache_o <= 1'b0;
            ack_o          <= r_snap;
            timeout_o      <= w_expire && !flush_dcache_ack_i;
          end
`ifdef FLUSH_ARB_TIMEOUT_EN
          else begin
            r_wd <= r_wd + 16'd1;
          end
`endif
        end
        DONE: begin
          r_state  <= IDLE;
          busy_o   <= 1'b0;
          r_rr_ptr <= w_ptr_next;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// Randomized round-level bench for dcache_flush_arbiter with a transaction-level reference model.
module tb_dcache_flush_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;
  localparam int GW  = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_i;
  logic [N-1:0]  ack_o;
  logic          flush_dcache_o;
  logic          flush_dcache_ack_i;
  logic          cache_busy_i;
  logic          busy_o;
  logic [GW-1:0] grant_id_o;
  logic          timeout_o;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           exp_ptr = 0;
  logic [N-1:0] pending = '0;

  dcache_flush_arbiter #(.NrReq(N), .TimeoutCycles(TMO)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_i              (req_i),
    .ack_o              (ack_o),
    .flush_dcache_o     (flush_dcache_o),
    .flush_dcache_ack_i (flush_dcache_ack_i),
    .cache_busy_i       (cache_busy_i),
    .busy_o             (busy_o),
    .grant_id_o         (grant_id_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Owner = first requested index at or after the pointer, wrapping upward.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One full round starting from an IDLE negedge; returns at the following IDLE negedge.
  task automatic run_round(input logic [N-1:0] new_bits, input int hold, input int dly,
                           input logic [N-1:0] late_in, input bit drop);
    logic [N-1:0] snap;
    logic [N-1:0] late;
    int g;
    int flush_len;
    bit tmo;
    snap = pending | new_bits;
    if (snap == '0) snap[$urandom_range(N - 1, 0)] = 1'b1;
    late = late_in & ~snap;
    req_i = snap;
    cache_busy_i = (hold > 0);
    flush_dcache_ack_i = 1'b0;
    for (int b = 0; b < hold; b++) begin
      flush_dcache_ack_i = 1'($urandom_range(1, 0));
      @(negedge clk_i);
      check("hold_flush", 32'(flush_dcache_o), 32'd0);
      check("hold_busy", 32'(busy_o), 32'd0);
    end
    cache_busy_i = 1'b0;
    flush_dcache_ack_i = 1'b0;
    g = pick(snap, exp_ptr);
    @(negedge clk_i);
    check("grant", 32'(grant_id_o), 32'(g));
    flush_len = dly + 1;
    tmo = 1'b0;
`ifdef FLUSH_ARB_TIMEOUT_EN
    if (flush_len > TMO) begin
      flush_len = TMO;
      tmo = 1'b1;
    end
`endif
    for (int j = 1; j <= flush_len; j++) begin
      check("flush_hi", 32'(flush_dcache_o), 32'd1);
      check("flush_busy", 32'(busy_o), 32'd1);
      check("flush_noack", 32'(ack_o), 32'd0);
      check("flush_notmo", 32'(timeout_o), 32'd0);
      if (j == 1) begin
        req_i = req_i | late;
        if (drop) req_i[g] = 1'b0;
      end
      flush_dcache_ack_i = (j == flush_len) && !tmo;
      @(negedge clk_i);
    end
    flush_dcache_ack_i = 1'($urandom_range(1, 0));
    check("done_ack", 32'(ack_o), 32'(snap));
    check("done_flush", 32'(flush_dcache_o), 32'd0);
    check("done_busy", 32'(busy_o), 32'd1);
    check("done_tmo", 32'(timeout_o), 32'(tmo));
    req_i = req_i & ~snap;
    pending = req_i;
    @(negedge clk_i);
    flush_dcache_ack_i = 1'b0;
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_ack", 32'(ack_o), 32'd0);
    check("idle_tmo", 32'(timeout_o), 32'd0);
    exp_ptr = (g + 1) % N;
    $display("[TB] round grant=%0d snap=%b hold=%0d flush_cycles=%0d late=%b drop=%0b timeout=%0b",
             g, snap, hold, flush_len, late, drop, tmo);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = '0;
    cache_busy_i = 1'b0;
    flush_dcache_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_flush", 32'(flush_dcache_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_grant", 32'(grant_id_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_round(3'b101, 0, 2, 3'b000, 1'b0);
    run_round(3'b001, 0, 5, 3'b000, 1'b0);
    run_round(3'b001, 0, 3, 3'b010, 1'b0);
    run_round(3'b000, 0, 1, 3'b000, 1'b0);
    run_round(3'b010, 4, 2, 3'b000, 1'b0);
    run_round(3'b011, 0, 0, 3'b000, 1'b1);
    run_round(3'b100, 0, 12, 3'b000, 1'b0);
    run_round(3'b110, 0, TMO - 1, 3'b000, 1'b0);

    for (int r = 0; r < 80; r++) begin
      if (pending == '0 && $urandom_range(3, 0) == 0) begin
        req_i = '0;
        repeat ($urandom_range(3, 1)) begin
          flush_dcache_ack_i = 1'($urandom_range(1, 0));
          @(negedge clk_i);
          check("gap_busy", 32'(busy_o), 32'd0);
        end
      end
      run_round(N'($urandom_range((1 << N) - 1, 0)),
                ($urandom_range(2, 0) == 0) ? int'($urandom_range(4, 1)) : 0,
                int'($urandom_range(12, 0)),
                N'($urandom_range((1 << N) - 1, 0)),
                $urandom_range(3, 0) == 0);
    end

    pending = '0;
    req_i = 3'b011;
    cache_busy_i = 1'b0;
    flush_dcache_ack_i = 1'b0;
    @(negedge clk_i);
    check("prerst_flush", 32'(flush_dcache_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i = '0;
    #1;
    check("midrst_flush", 32'(flush_dcache_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_grant", 32'(grant_id_o), 32'd0);
    check("midrst_ack", 32'(ack_o), 32'd0);
    repeat (3) begin
      flush_dcache_ack_i = 1'b1;
      @(negedge clk_i);
      check("inrst_ack", 32'(ack_o), 32'd0);
      check("inrst_tmo", 32'(timeout_o), 32'd0);
    end
    flush_dcache_ack_i = 1'b0;
    rst_ni = 1'b1;
    exp_ptr = 0;
    @(negedge clk_i);
    check("postrst_ack", 32'(ack_o), 32'd0);
    check("postrst_busy", 32'(busy_o), 32'd0);
    run_round(3'b110, 0, 2, 3'b000, 1'b0);
    run_round(3'b111, 1, 0, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dcache_flush_arbiter.md
DCACHE_FLUSH_ARBITER -- requirements
Module: dcache_flush_arbiter

Interface
REQ-001 Parameter NrReq, default 3, number of flush requesters (fence, fence.i, fence.t); legal range 1..8.
REQ-002 Parameter TimeoutCycles, default 1024, watchdog limit in cycles; legal range 2..65535.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 req_i  input  NrReq  per-requester flush request; level, held until the matching ack_o pulse.
REQ-006 ack_o  output  NrReq  per-requester one-cycle flush-complete pulse.
REQ-007 flush_dcache_o  output  1  registered dcache flush request.
REQ-008 flush_dcache_ack_i  input  1  dcache flush-complete pulse.
REQ-009 cache_busy_i  input  1  dcache has outstanding external transactions.
REQ-010 busy_o  output  1  high whenever state is not IDLE; used as a halt source.
REQ-011 grant_id_o  output  $clog2(NrReq) (min 1)  index of the owning requester; valid while busy_o is high.
REQ-012 timeout_o  output  1  one-cycle pulse when the watchdog aborts a flush.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, FLUSH and DONE.
REQ-014 IDLE: if |req_i and !cache_busy_i, it SHALL go to FLUSH next cycle; otherwise it SHALL stay in IDLE.
REQ-015 On leaving IDLE, grant_id_o SHALL be the first set req_i bit at or after rr_ptr, searching upward with wrap-around.
REQ-016 On leaving IDLE, snapshot mask snap_q SHALL capture req_i.
REQ-017 flush_dcache_o SHALL be 1 in every FLUSH cycle and 0 in IDLE and DONE; first assertion is 1 cycle after the request is accepted.
REQ-018 FLUSH: flush_dcache_ack_i=1 SHALL move the FSM to DONE next cycle.
REQ-019 DONE SHALL last exactly 1 cycle, with ack_o = snap_q (coalesced completion); then the FSM SHALL go to IDLE.
REQ-020 Requests that rise after the snapshot SHALL NOT be acked in the current round; they are served in a later round.
REQ-021 In DONE, rr_ptr SHALL become (grant_id_o+1) mod NrReq.
REQ-022 ack_o SHALL be 0 in every state other than DONE.
REQ-023 flush_dcache_ack_i SHALL be ignored in IDLE and DONE.
REQ-024 A req_i bit deasserted before its ack SHALL still be acked if it was in snap_q.
REQ-025 Requester-side contract: deassert req_i in the cycle after ack_o; a request still held is treated as a new request.
REQ-026 Minimum request-to-ack latency SHALL be 3 cycles (accept, FLUSH with same-cycle dcache ack, DONE).

Reset
REQ-027 While rst_ni=0: state=IDLE, rr_ptr=0, snap_q=0, watchdog=0, flush_dcache_o=0, ack_o=0, busy_o=0, grant_id_o=0, timeout_o=0.
REQ-028 Reset mid-FLUSH SHALL abort the round without issuing any ack_o.

Configuration
REQ-029 Macro FLUSH_ARB_TIMEOUT_EN SHALL compile the watchdog feature in or out.
REQ-030 With FLUSH_ARB_TIMEOUT_EN: a 16-bit counter SHALL clear on FLUSH entry and increment each FLUSH cycle without an ack.
REQ-031 With FLUSH_ARB_TIMEOUT_EN: when the counter reaches TimeoutCycles-1 without an ack, the FSM SHALL go to DONE, timeout_o SHALL pulse in DONE, and ack_o SHALL still equal snap_q.
REQ-032 With FLUSH_ARB_TIMEOUT_EN: an ack in the same cycle as expiry SHALL take priority, with no timeout_o pulse.
REQ-033 Without FLUSH_ARB_TIMEOUT_EN: no counter SHALL exist, timeout_o SHALL be constant 0, and FLUSH SHALL wait for the ack indefinitely.

Verification
REQ-034 req_i=3'b001, dcache acks 5 cycles after flush_dcache_o rises -> flush_dcache_o high for 6 cycles; ack_o=3'b001 for 1 cycle; busy_o then falls.
REQ-035 req_i=3'b101 together, rr_ptr=0 -> grant_id_o=0; one flush; ack_o=3'b101 in DONE; rr_ptr becomes 1.
REQ-036 req_i[1] rises during FLUSH of requester 0 -> ack_o=3'b001 only; second round starts; grant_id_o=1, ack_o=3'b010.
REQ-037 cache_busy_i=1 for 4 cycles while req_i=3'b010 -> flush_dcache_o stays 0 until busy drops; then normal round.
REQ-038 With the macro, TimeoutCycles=8, no dcache ack -> flush_dcache_o high 8 cycles; timeout_o and ack_o pulse together. Without the macro, the FSM stays in FLUSH.
REQ-039 rst_ni low during FLUSH, then released -> all outputs 0, no ack_o pulse; a fresh request is served normally.
